// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared CPU widths, ALU op codes and the ID/EX stage register layout
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_XOR = 3'd5
  } alu_op_e;

  // alu_sel stays a raw 3-bit code: 6 and 7 must pass through untouched
  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [2:0]        alu_sel;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
  } id_ex_fields_t;

  function automatic logic fwd_hit(input logic             we,
                                   input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode, forwarding and execute signals of the ID/EX stage
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_rs1;
  logic [REG_W-1:0]  in_rs2;
  logic [REG_W-1:0]  in_rd;
  logic [DATA_W-1:0] in_rs1_data;
  logic [DATA_W-1:0] in_rs2_data;
  logic [DATA_W-1:0] in_imm;
  logic              in_use_imm;
  logic [2:0]        in_alu_sel;
  logic              in_reg_write;
  logic              in_mem_read;
  logic              in_mem_write;
  logic              in_branch;

  logic [REG_W-1:0]  exmem_rd;
  logic              exmem_reg_write;
  logic [DATA_W-1:0] exmem_result;
  logic [REG_W-1:0]  memwb_rd;
  logic              memwb_reg_write;
  logic [DATA_W-1:0] memwb_result;
  logic              flush;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_sel;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  out_rd;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_branch;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm,
           in_use_imm, in_alu_sel, in_reg_write, in_mem_read, in_mem_write, in_branch,
           exmem_rd, exmem_reg_write, exmem_result, memwb_rd, memwb_reg_write,
           memwb_result, flush, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_sel, store_data, out_rd,
           out_reg_write, out_mem_read, out_mem_write, out_branch
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm,
           in_use_imm, in_alu_sel, in_reg_write, in_mem_read, in_mem_write, in_branch,
           exmem_rd, exmem_reg_write, exmem_result, memwb_rd, memwb_reg_write,
           memwb_result, flush, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_sel, store_data, out_rd,
           out_reg_write, out_mem_read, out_mem_write, out_branch
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// rtl/id_ex_stage_fwd_mux.sv - operand forwarding select, EX/MEM over MEM/WB over register file
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [REG_W-1:0]  rs,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = reg_data;
    if (fwd_hit(exmem_reg_write, exmem_rd, rs)) begin
      data = exmem_result;
    end else if (fwd_hit(memwb_reg_write, memwb_rd, rs)) begin
      data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, flush and operand forwarding
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  id_ex_fields_t     held_q;
  id_ex_fields_t     in_f;
  logic              valid_q;
  logic              stall;
  logic              accept;
  logic [DATA_W-1:0] fwd_rs1;
  logic [DATA_W-1:0] fwd_rs2;

  assign in_f = '{
    rs1:       bus.in_rs1,
    rs2:       bus.in_rs2,
    rd:        bus.in_rd,
    rs1_data:  bus.in_rs1_data,
    rs2_data:  bus.in_rs2_data,
    imm:       bus.in_imm,
    use_imm:   bus.in_use_imm,
    alu_sel:   bus.in_alu_sel,
    reg_write: bus.in_reg_write,
    mem_read:  bus.in_mem_read,
    mem_write: bus.in_mem_write,
    branch:    bus.in_branch
  };

  // rs2 only matters to the consumer when it is an ALU operand or store data
  assign stall = valid_q && held_q.mem_read && (held_q.rd != '0) && bus.in_valid &&
                 ((bus.in_rs1 == held_q.rd) ||
                  ((!bus.in_use_imm || bus.in_mem_write) && (bus.in_rs2 == held_q.rd)));

  assign bus.in_ready = rst_n && !stall && !bus.flush && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      held_q  <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      held_q  <= in_f;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  fwd_mux u_fwd_rs1 (
    .rs              (held_q.rs1),
    .reg_data        (held_q.rs1_data),
    .exmem_rd        (bus.exmem_rd),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_result    (bus.exmem_result),
    .memwb_rd        (bus.memwb_rd),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_result    (bus.memwb_result),
    .data            (fwd_rs1)
  );

  fwd_mux u_fwd_rs2 (
    .rs              (held_q.rs2),
    .reg_data        (held_q.rs2_data),
    .exmem_rd        (bus.exmem_rd),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_result    (bus.exmem_result),
    .memwb_rd        (bus.memwb_rd),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_result    (bus.memwb_result),
    .data            (fwd_rs2)
  );

  assign bus.out_valid     = valid_q;
  assign bus.alu_a         = fwd_rs1;
  assign bus.alu_b         = held_q.use_imm ? held_q.imm : fwd_rs2;
  assign bus.store_data    = fwd_rs2;
  assign bus.alu_sel       = held_q.alu_sel;
  assign bus.out_rd        = held_q.rd;
  assign bus.out_reg_write = held_q.reg_write && valid_q;
  assign bus.out_mem_read  = held_q.mem_read  && valid_q;
  assign bus.out_mem_write = held_q.mem_write && valid_q;
  assign bus.out_branch    = held_q.branch    && valid_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low).
REQ-002 SHALL have decode-side ports: in_valid in 1; in_ready out 1; in_rs1 in 5; in_rs2 in 5; in_rd in 5; in_rs1_data in 32; in_rs2_data in 32; in_imm in 32; in_use_imm in 1; in_alu_sel in 3; in_reg_write in 1; in_mem_read in 1; in_mem_write in 1; in_branch in 1.
REQ-003 SHALL have forwarding ports: exmem_rd in 5; exmem_reg_write in 1; exmem_result in 32; memwb_rd in 5; memwb_reg_write in 1; memwb_result in 32; flush in 1 (squash held and incoming instruction).
REQ-004 SHALL have execute-side ports: out_valid out 1; out_ready in 1; alu_a out 32; alu_b out 32; alu_sel out 3; store_data out 32; out_rd out 5; out_reg_write out 1; out_mem_read out 1; out_mem_write out 1; out_branch out 1.

Function
REQ-005 SHALL hold one instruction in a stage register (valid_q plus all in_* fields) feeding the ALU operands a, b and sel.
REQ-006 SHALL drive in_ready = !stall && !flush && (!valid_q || out_ready), combinationally.
REQ-007 SHALL capture in_* fields and set valid_q=1 on a clock edge where in_valid && in_ready.
REQ-008 SHALL clear valid_q on an edge where valid_q && out_ready && !(in_valid && in_ready); held fields may remain stale.
REQ-009 SHALL hold the register unchanged while valid_q && !out_ready (backpressure); out_* stable throughout.
REQ-010 SHALL assert stall when valid_q && mem_read_q && rd_q!=0 && in_valid && (in_rs1==rd_q || (!in_use_imm || in_mem_write) && in_rs2==rd_q) (load-use); the held load drains normally, leaving a one-cycle bubble.
REQ-011 SHALL, on an edge with flush=1, clear valid_q and discard any incoming instruction; flush overrides accept, hold and stall.
REQ-012 SHALL compute forwarded rs1/rs2 combinationally from the held indices: EX/MEM result if exmem_reg_write && exmem_rd!=0 && exmem_rd==rs; else MEM/WB result under the same rule; else held register data.
REQ-013 SHALL give EX/MEM priority over MEM/WB when both match; index 0 SHALL never forward.
REQ-014 SHALL drive alu_a = fwd_rs1; alu_b = use_imm_q ? imm_q : fwd_rs2; store_data = fwd_rs2; alu_sel = alu_sel_q.
REQ-015 SHALL gate control outputs: out_reg_write, out_mem_read, out_mem_write, out_branch = held value && valid_q; out_valid = valid_q.
REQ-016 SHALL pass alu_sel codes unmodified; codes 6-7 are legal inputs and yield ALU result 0.

Reset
REQ-017 SHALL, on an edge with rst_n=0, clear valid_q and all held fields to 0, overriding every other input.
REQ-018 SHALL therefore present out_valid=0, all control outputs 0, alu_a=alu_b=store_data=0 (absent forwarding matches on x0), alu_sel=0 after reset.
REQ-019 SHALL hold in_ready=0 while rst_n=0.

Structure
REQ-020 SHALL take DATA_W=32, REG_W=5 and ALU op codes (ADD=0, SUB=1, AND=2, OR=3, SLT=4, XOR=5) from the shared CPU package.
REQ-021 SHALL implement the forwarding selection once as sub-module fwd_mux, instantiated for rs1 and rs2.

Verification
REQ-022 Accept rs1=3(data 10), rs2=4(data 20), use_imm=0, sel=ADD, out_ready=1 -> next cycle out_valid=1, alu_a=10, alu_b=20, alu_sel=0.
REQ-023 Held rs1=5, exmem_rd=5 write result 0x77, memwb_rd=5 write result 0x11 -> alu_a=0x77; drop exmem_reg_write -> alu_a=0x11; rs1=0 with exmem_rd=0 -> alu_a=0.
REQ-024 Held load rd=7, incoming in_rs1=7 in_valid=1 -> in_ready=0 one cycle, out_valid=0 following cycle, instruction accepted after.
REQ-025 out_ready=0 for 3 cycles with valid_q=1 -> in_ready=0, outputs constant; out_ready=1 -> advance in one edge.
REQ-026 flush=1 with in_valid=1, valid_q=1 -> next cycle out_valid=0, incoming not captured; rst_n=0 mid-stream -> out_valid=0, all controls 0.
